// File: rtl/mpbuffer_noc_port_pkg.sv
// ----------------------------------------------------------------------------
// mpbuffer_noc_port_pkg
//
// Shared definitions for the message-passing buffer NoC port:
//   - CFG_SEL_LSB : bit position of the endpoint selector in a header flit.
//                   The endpoint software builds headers from the same value.
//   - clog2_width : number of bits needed to index 'value' items (minimum 1).
// ----------------------------------------------------------------------------
package mpbuffer_noc_port_pkg;

    localparam int CFG_SEL_LSB = 16;

    function automatic int clog2_width(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/mpbuffer_rr_arb.sv
// ----------------------------------------------------------------------------
// mpbuffer_rr_arb
//
// Combinational round-robin pick. Searches the request vector starting at the
// index just after last_winner (wrapping modulo N) and returns a one-hot grant
// for the first requester found, or all zeros when nothing requests.
//
// Ports:
//   req          in   N   Request vector.
//   last_winner  in   W   Index of the previous winner.
//   grant        out  N   One-hot grant, or zero.
// ----------------------------------------------------------------------------
module mpbuffer_rr_arb
    import mpbuffer_noc_port_pkg::*;
#(
    parameter int N = 2,
    parameter int W = clog2_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_winner,
    output logic [N-1:0] grant
);

    always_comb begin
        logic found;
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        grant = '0;
        found = 1'b0;
        // Offset k walks the candidates in priority order; j matches the
        // candidate index so every select stays a loop constant.
        for (int k = 1; k <= N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && req[j] && ((int'(last_winner) + k) % N == j)) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mpbuffer_noc_port.sv
// ----------------------------------------------------------------------------
// mpbuffer_noc_port
//
// Shares one NoC link pair between EP_COUNT message-passing buffer endpoints.
//   Egress : whole packets from the endpoints are arbitrated round-robin onto
//            noc_out; a granted packet owns the link until its last flit.
//   Ingress: each noc_in packet goes to the endpoint named by the selector
//            field of its header flit; unknown selectors are consumed and
//            counted in drop_count.
//
// Ports:
//   clk, rst                                 Clock, synchronous active-high reset.
//   ep_out_flit/last/valid, ep_out_ready     Endpoint egress streams (packed by index).
//   noc_out_flit/last/valid, noc_out_ready   Stream to the router.
//   noc_in_flit/last/valid, noc_in_ready     Stream from the router.
//   ep_in_flit/last (broadcast), ep_in_valid (one-hot), ep_in_ready
//                                            Endpoint ingress streams.
//   drop_count                               Saturating count of dropped packets.
// ----------------------------------------------------------------------------
module mpbuffer_noc_port
    import mpbuffer_noc_port_pkg::*;
#(
    parameter int FLIT_WIDTH = 32,
    parameter int EP_COUNT   = 2,
    parameter int SEL_LSB    = CFG_SEL_LSB
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [EP_COUNT*FLIT_WIDTH-1:0] ep_out_flit,
    input  logic [EP_COUNT-1:0]            ep_out_last,
    input  logic [EP_COUNT-1:0]            ep_out_valid,
    output logic [EP_COUNT-1:0]            ep_out_ready,
    output logic [FLIT_WIDTH-1:0]          noc_out_flit,
    output logic                           noc_out_last,
    output logic                           noc_out_valid,
    input  logic                           noc_out_ready,
    input  logic [FLIT_WIDTH-1:0]          noc_in_flit,
    input  logic                           noc_in_last,
    input  logic                           noc_in_valid,
    output logic                           noc_in_ready,
    output logic [FLIT_WIDTH-1:0]          ep_in_flit,
    output logic                           ep_in_last,
    output logic [EP_COUNT-1:0]            ep_in_valid,
    input  logic [EP_COUNT-1:0]            ep_in_ready,
    output logic [15:0]                    drop_count
);

    localparam int EPW = clog2_width(EP_COUNT);

    typedef enum logic {E_IDLE, E_LOCKED} egress_state_t;
    typedef enum logic [1:0] {I_HEAD, I_BODY, I_DROP} ingress_state_t;

    // ------------------------------------------------------------------
    // Egress
    // ------------------------------------------------------------------
    egress_state_t         e_state;
    logic [EPW-1:0]        grant;
    logic [EPW-1:0]        last_winner;
    logic [EP_COUNT-1:0]   arb_onehot;
    logic [EPW-1:0]        arb_index;

    mpbuffer_rr_arb #(.N(EP_COUNT)) u_arb (
        .req         (ep_out_valid),
        .last_winner (last_winner),
        .grant       (arb_onehot)
    );

    always_comb begin
        arb_index = '0;
        for (int i = 0; i < EP_COUNT; i++) begin
            if (arb_onehot[i]) arb_index = EPW'(i);
        end
    end

    // The grant is only taken in E_IDLE, which is what produces the single
    // bubble cycle between packets and keeps packets from interleaving.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            e_state     <= E_IDLE;
            grant       <= '0;
            last_winner <= EPW'(EP_COUNT - 1);
        end else begin
            case (e_state)
                E_IDLE: begin
                    if (|ep_out_valid) begin
                        grant   <= arb_index;
                        e_state <= E_LOCKED;
                    end
                end
                E_LOCKED: begin
                    if (noc_out_valid && noc_out_ready && noc_out_last) begin
                        last_winner <= grant;
                        e_state     <= E_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        noc_out_flit  = '0;
        noc_out_last  = 1'b0;
        noc_out_valid = 1'b0;
        ep_out_ready  = '0;
        for (int i = 0; i < EP_COUNT; i++) begin
            if (e_state == E_LOCKED && grant == EPW'(i)) begin
                noc_out_flit    = ep_out_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
                noc_out_last    = ep_out_last[i];
                noc_out_valid   = ep_out_valid[i];
                ep_out_ready[i] = noc_out_ready;
            end
        end
    end

    // ------------------------------------------------------------------
    // Ingress
    // ------------------------------------------------------------------
    ingress_state_t  i_state;
    logic [EPW-1:0]  cur;
    logic [EPW-1:0]  sel;
    logic            sel_hit;
    logic            route_valid;
    logic [EPW-1:0]  route_index;

    assign sel        = noc_in_flit[SEL_LSB +: EPW];
    assign ep_in_flit = noc_in_flit;
    assign ep_in_last = noc_in_last;

    always_comb begin
        sel_hit = 1'b0;
        for (int i = 0; i < EP_COUNT; i++) begin
            if (sel == EPW'(i)) sel_hit = 1'b1;
        end

        // Body flits follow the latched target; a header routes by its own
        // selector. Anything else (bad selector, I_DROP) is sunk.
        route_valid = (i_state == I_BODY) || (i_state == I_HEAD && sel_hit);
        route_index = (i_state == I_BODY) ? cur : sel;

        ep_in_valid  = '0;
        noc_in_ready = 1'b1;
        if (route_valid) begin
            noc_in_ready = 1'b0;
            for (int i = 0; i < EP_COUNT; i++) begin
                if (route_index == EPW'(i)) begin
                    ep_in_valid[i] = noc_in_valid;
                    noc_in_ready   = ep_in_ready[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_state    <= I_HEAD;
            cur        <= '0;
            drop_count <= '0;
        end else if (noc_in_valid && noc_in_ready) begin
            case (i_state)
                I_HEAD: begin
                    if (sel_hit) begin
                        if (!noc_in_last) begin
                            cur     <= sel;
                            i_state <= I_BODY;
                        end
                    end else begin
                        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                        if (!noc_in_last) i_state <= I_DROP;
                    end
                end
                I_BODY, I_DROP: begin
                    if (noc_in_last) i_state <= I_HEAD;
                end
                default: i_state <= I_HEAD;
            endcase
        end
    end

endmodule

// File: tb/tb_mpbuffer_noc_port.sv
// ----------------------------------------------------------------------------
// tb_mpbuffer_noc_port
//
// Drives random and directed traffic on both link directions and compares the
// DUT each cycle against a packet-level model: an owner/last-winner pair for
// egress and a head/body/drop mode plus target index for ingress.
// EP_COUNT is 3 so a 2-bit selector exists and selector 3 is a drop.
// ----------------------------------------------------------------------------
module tb_mpbuffer_noc_port;

    localparam int FW = 32;
    localparam int EP = 3;
    localparam int SL = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [EP*FW-1:0]   ep_out_flit = '0;
    logic [EP-1:0]      ep_out_last = '0;
    logic [EP-1:0]      ep_out_valid = '0;
    logic [EP-1:0]      ep_out_ready;
    logic [FW-1:0]      noc_out_flit;
    logic               noc_out_last;
    logic               noc_out_valid;
    logic               noc_out_ready = 1'b0;
    logic [FW-1:0]      noc_in_flit = '0;
    logic               noc_in_last = 1'b0;
    logic               noc_in_valid = 1'b0;
    logic               noc_in_ready;
    logic [FW-1:0]      ep_in_flit;
    logic               ep_in_last;
    logic [EP-1:0]      ep_in_valid;
    logic [EP-1:0]      ep_in_ready = '0;
    logic [15:0]        drop_count;

    mpbuffer_noc_port #(.FLIT_WIDTH(FW), .EP_COUNT(EP), .SEL_LSB(SL)) dut (
        .clk           (clk),
        .rst           (rst),
        .ep_out_flit   (ep_out_flit),
        .ep_out_last   (ep_out_last),
        .ep_out_valid  (ep_out_valid),
        .ep_out_ready  (ep_out_ready),
        .noc_out_flit  (noc_out_flit),
        .noc_out_last  (noc_out_last),
        .noc_out_valid (noc_out_valid),
        .noc_out_ready (noc_out_ready),
        .noc_in_flit   (noc_in_flit),
        .noc_in_last   (noc_in_last),
        .noc_in_valid  (noc_in_valid),
        .noc_in_ready  (noc_in_ready),
        .ep_in_flit    (ep_in_flit),
        .ep_in_last    (ep_in_last),
        .ep_in_valid   (ep_in_valid),
        .ep_in_ready   (ep_in_ready),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Stimulus state: beats are {last, flit}.
    logic [FW:0] src_q [EP][$];
    logic [FW:0] in_q [$];
    bit          src_first [EP];
    bit          eg_hs [EP];
    bit          in_hs;
    int          eg_rate = 100, in_rate = 100, rdy_rate = 100, out_rdy_rate = 100;
    bit          toggle_mode = 1'b0;

    // Reference model state.
    int          m_owner;     // -1 when the egress link is free
    int          m_lw;        // last egress winner
    int          m_mode;      // 0 = expecting header, 1 = body to m_cur, 2 = dropping
    int          m_cur;
    logic [15:0] m_drops;
    bit          prev_stall;
    logic [FW:0] prev_beat;

    int          grant_log [$];
    logic [EP-1:0] in_log [$];

    // Snapshots of the last compared cycle for directed literal checks.
    logic          snap_noc_valid, snap_noc_last, snap_in_hs;
    logic [FW-1:0] snap_noc_flit;
    logic [EP-1:0] snap_ep_rdy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner    = -1;
        m_lw       = EP - 1;
        m_mode     = 0;
        m_cur      = 0;
        m_drops    = '0;
        prev_stall = 1'b0;
    endtask

    // Called at the negedge: compare outputs with the model, then advance it
    // by what the coming posedge will do.
    task automatic compare();
        logic [EP-1:0] exp_rdy;
        logic [EP-1:0] exp_vld;
        int            sel;
        int            target;
        logic          exp_in_rdy;

        for (int e = 0; e < EP; e++) eg_hs[e] = ep_out_valid[e] && ep_out_ready[e];
        in_hs          = noc_in_valid && noc_in_ready;
        snap_noc_valid = noc_out_valid;
        snap_noc_last  = noc_out_last;
        snap_noc_flit  = noc_out_flit;
        snap_ep_rdy    = ep_out_ready;
        snap_in_hs     = in_hs;

        // A stalled flit must be presented unchanged next cycle.
        if (prev_stall) begin
            check("eg_hold_valid", noc_out_valid, 1);
            check("eg_hold_beat", {noc_out_last, noc_out_flit}, prev_beat);
        end
        prev_stall = noc_out_valid && !noc_out_ready;
        prev_beat  = {noc_out_last, noc_out_flit};

        if (m_owner < 0) begin
            check("eg_idle_valid", noc_out_valid, 0);
            check("eg_idle_ready", ep_out_ready, 0);
            for (int k = 1; k <= EP; k++) begin
                if (m_owner < 0 && ep_out_valid[(m_lw + k) % EP]) m_owner = (m_lw + k) % EP;
            end
        end else begin
            exp_rdy          = '0;
            exp_rdy[m_owner] = noc_out_ready;
            check("eg_valid", noc_out_valid, ep_out_valid[m_owner]);
            check("eg_ready", ep_out_ready, exp_rdy);
            if (ep_out_valid[m_owner]) begin
                check("eg_beat", {noc_out_last, noc_out_flit},
                      {ep_out_last[m_owner], ep_out_flit[m_owner*FW +: FW]});
                if (noc_out_ready && ep_out_last[m_owner]) begin
                    m_lw    = m_owner;
                    m_owner = -1;
                end
            end
        end
        for (int e = 0; e < EP; e++) begin
            if (eg_hs[e] && src_first[e]) grant_log.push_back(e);
        end

        sel = int'(noc_in_flit[SL +: 2]);
        if (m_mode == 1)                  target = m_cur;
        else if (m_mode == 0 && sel < EP) target = sel;
        else                              target = -1;
        exp_in_rdy = (target >= 0) ? ep_in_ready[target] : 1'b1;
        exp_vld    = '0;
        if (target >= 0 && noc_in_valid) exp_vld[target] = 1'b1;
        check("in_valid", ep_in_valid, exp_vld);
        check("in_ready", noc_in_ready, exp_in_rdy);
        check("in_beat", {ep_in_last, ep_in_flit}, {noc_in_last, noc_in_flit});
        check("drop_count", drop_count, m_drops);
        if (ep_in_valid != '0) in_log.push_back(ep_in_valid);

        if (noc_in_valid && exp_in_rdy) begin
            if (m_mode == 0) begin
                if (target < 0) begin
                    if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
                    m_mode = noc_in_last ? 0 : 2;
                end else begin
                    m_cur  = target;
                    m_mode = noc_in_last ? 0 : 1;
                end
            end else if (noc_in_last) begin
                m_mode = 0;
            end
        end
    endtask

    // Called just after the posedge: retire accepted beats, present new ones.
    task automatic drive();
        logic [FW:0] beat;
        for (int e = 0; e < EP; e++) begin
            if (eg_hs[e]) begin
                beat            = src_q[e].pop_front();
                src_first[e]    = beat[FW];
                ep_out_valid[e] = 1'b0;
            end
            if (!ep_out_valid[e] && src_q[e].size() > 0 && $urandom_range(99) < eg_rate) begin
                beat                    = src_q[e][0];
                ep_out_valid[e]         = 1'b1;
                ep_out_flit[e*FW +: FW] = beat[FW-1:0];
                ep_out_last[e]          = beat[FW];
            end
            eg_hs[e] = 1'b0;
        end
        noc_out_ready = toggle_mode ? ~noc_out_ready : ($urandom_range(99) < out_rdy_rate);

        if (in_hs) begin
            beat         = in_q.pop_front();
            noc_in_valid = 1'b0;
        end
        in_hs = 1'b0;
        if (!noc_in_valid) begin
            if (in_q.size() > 0 && $urandom_range(99) < in_rate) begin
                beat         = in_q[0];
                noc_in_valid = 1'b1;
                noc_in_flit  = beat[FW-1:0];
                noc_in_last  = beat[FW];
            end else begin
                noc_in_flit = $urandom;
                noc_in_last = 1'($urandom_range(1));
            end
        end
        for (int e = 0; e < EP; e++) ep_in_ready[e] = ($urandom_range(99) < rdy_rate);
    endtask

    task automatic cycle();
        @(negedge clk);
        if (rst) begin
            for (int e = 0; e < EP; e++) eg_hs[e] = 1'b0;
            in_hs = 1'b0;
        end else begin
            compare();
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int e = 0; e < EP; e++) begin
            src_q[e].delete();
            ep_out_valid[e] = 1'b0;
            src_first[e]    = 1'b1;
        end
        in_q.delete();
        noc_in_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic post_reset_literals(input string tag);
        @(negedge clk);
        check({tag, "_noc_out_valid"}, noc_out_valid, 0);
        check({tag, "_ep_out_ready"}, ep_out_ready, 0);
        check({tag, "_ep_in_valid"}, ep_in_valid, 0);
        check({tag, "_drop_count"}, drop_count, 0);
        compare();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic push_eg(input int e, input int len);
        for (int i = 0; i < len; i++) src_q[e].push_back({1'(i == len - 1), 32'($urandom)});
    endtask

    task automatic push_in(input int sel, input int len);
        logic [FW:0] beat;
        for (int i = 0; i < len; i++) begin
            beat = {1'(i == len - 1), 32'($urandom)};
            if (i == 0) beat[SL +: 2] = 2'(sel);
            in_q.push_back(beat);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [FW-1:0] t2_flit [3];
        int            consumed;
        bit            done;

        model_reset();
        do_reset(2);
        post_reset_literals("reset");

        // Single 3-flit packet: bubble, three flits, idle again.
        t2_flit[0] = 32'hA000_0001;
        t2_flit[1] = 32'hA000_0002;
        t2_flit[2] = 32'hA000_0003;
        src_q[0].push_back({1'b0, t2_flit[0]});
        src_q[0].push_back({1'b0, t2_flit[1]});
        src_q[0].push_back({1'b1, t2_flit[2]});
        drive();
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("single_valid", snap_noc_valid, (k >= 1 && k <= 3));
            if (k >= 1 && k <= 3) begin
                check("single_flit", snap_noc_flit, t2_flit[k-1]);
                check("single_last", snap_noc_last, (k == 3));
            end
        end
        check("single_idle_ready", snap_ep_rdy, 0);

        // Fairness: EP0 and EP1 saturated with 2-flit packets.
        do_reset(1);
        for (int p = 0; p < 4; p++) begin
            push_eg(0, 2);
            push_eg(1, 2);
        end
        grant_log.delete();
        drive();
        for (int k = 0; k < 30; k++) cycle();
        check("fair_count", grant_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check("fair_order", (i < grant_log.size()) ? grant_log[i] : -1, i % 2);
        end

        // Backpressure: ready toggles while EP1 waits behind EP0.
        push_eg(0, 4);
        push_eg(1, 2);
        grant_log.delete();
        toggle_mode = 1'b1;
        drive();
        for (int k = 0; k < 20; k++) cycle();
        toggle_mode = 1'b0;
        check("bp_count", grant_log.size(), 2);
        check("bp_first", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
        check("bp_second", (grant_log.size() > 1) ? grant_log[1] : -1, 1);

        // Ingress dispatch: 4 flits to EP1, then a single flit to EP0.
        in_log.delete();
        push_in(1, 4);
        push_in(0, 1);
        drive();
        for (int k = 0; k < 8; k++) cycle();
        check("disp_count", in_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check("disp_target", (i < in_log.size()) ? in_log[i] : 3'b111, (i < 4) ? 3'b010 : 3'b001);
        end

        // Drop: selector 3 with every endpoint stalled.
        check("drop_before", drop_count, 0);
        rdy_rate = 0;
        in_log.delete();
        push_in(3, 3);
        drive();
        consumed = 0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (snap_in_hs) consumed++;
        end
        check("drop_consumed", consumed, 3);
        check("drop_no_valid", in_log.size(), 0);
        check("drop_after", drop_count, 1);

        // Saturation: preload the counter at its ceiling.
        force dut.drop_count = 16'hFFFF;
        m_drops = 16'hFFFF;
        cycle();
        release dut.drop_count;
        push_in(3, 2);
        drive();
        for (int k = 0; k < 4; k++) cycle();
        check("drop_saturated", drop_count, 16'hFFFF);
        rdy_rate = 100;

        // Reset in the middle of an egress and an ingress packet.
        push_eg(0, 4);
        push_in(1, 4);
        drive();
        cycle();
        cycle();
        check("mid_pkt_active", snap_noc_valid, 1);
        do_reset(1);
        post_reset_literals("midrst");
        grant_log.delete();
        in_log.delete();
        push_eg(1, 1);
        push_eg(0, 1);
        push_in(0, 1);
        drive();
        for (int k = 0; k < 8; k++) cycle();
        check("midrst_grant0", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
        check("midrst_grant1", (grant_log.size() > 1) ? grant_log[1] : -1, 1);
        check("midrst_route", (in_log.size() > 0) ? in_log[0] : 3'b111, 3'b001);

        // Random traffic on both directions at once.
        eg_rate = 70; in_rate = 70; rdy_rate = 70; out_rdy_rate = 70;
        for (int n = 0; n < 3000; n++) begin
            for (int e = 0; e < EP; e++) begin
                if (src_q[e].size() < 3 && $urandom_range(3) == 0) push_eg(e, $urandom_range(1, 4));
            end
            if (in_q.size() < 3 && $urandom_range(2) == 0) push_in($urandom_range(3), $urandom_range(1, 4));
            cycle();
        end

        eg_rate = 100; in_rate = 100; rdy_rate = 100; out_rdy_rate = 100;
        done = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            cycle();
            done = (src_q[0].size() == 0) && (src_q[1].size() == 0) && (src_q[2].size() == 0)
                   && (in_q.size() == 0) && (ep_out_valid == '0) && !noc_in_valid;
        end
        check("drain_complete", done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
